// File: rtl/n64_vbus_if.sv
// rtl/n64_vbus_if.sv - N64 digital video bus signal bundle (nDSYNC, D, field, sof)
interface n64_vbus_if;
   logic       nDSYNC;
   logic [6:0] D;
   logic       field;
   logic       sof;

   modport master (output nDSYNC, D, field, sof);
   modport slave  (input  nDSYNC, D, field, sof);
endinterface

// File: rtl/n64_vbus_gen.sv
// rtl/n64_vbus_gen.sv - N64 video bus transmitter: 4-slot muxed sync/RGB stream with colour bars
module n64_vbus_gen #(
   parameter int H_TOTAL      = 773,
   parameter int HSYNC_LEN    = 58,
   parameter int CLAMP_START  = 64,
   parameter int CLAMP_LEN    = 32,
   parameter int H_ACT_START  = 108,
   parameter int BAR_W        = 80,
   parameter int V_TOTAL_NTSC = 263,
   parameter int V_TOTAL_PAL  = 313,
   parameter int VSYNC_LEN    = 3,
   parameter int V_ACT_START  = 20,
   parameter int V_ACT_NTSC   = 240,
   parameter int V_ACT_PAL    = 288
) (
   input  logic        nCLK,
   input  logic        RST,
   input  logic        vmode_i,
   input  logic        n480i_i,
   input  logic        pat_en_i,
   n64_vbus_if.master  vbus
);

   localparam int PW = $clog2(H_TOTAL);
   localparam int LW = $clog2(V_TOTAL_PAL);

   localparam logic [PW-1:0] PIX_LAST = PW'(H_TOTAL - 1);
   localparam logic [PW-1:0] PIX_HALF = PW'(H_TOTAL / 2);
   localparam logic [PW-1:0] HS_END   = PW'(HSYNC_LEN);
   localparam logic [PW-1:0] CL_START = PW'(CLAMP_START);
   localparam logic [PW-1:0] CL_END   = PW'(CLAMP_START + CLAMP_LEN);
   localparam logic [PW-1:0] ACT_X0   = PW'(H_ACT_START);
   localparam logic [PW-1:0] ACT_X1   = PW'(H_ACT_START + 8 * BAR_W);
   localparam logic [PW-1:0] BAR_WP   = PW'(BAR_W);

   localparam logic [LW-1:0] VS_LINES = LW'(VSYNC_LEN);
   localparam logic [LW-1:0] VT_NTSC  = LW'(V_TOTAL_NTSC);
   localparam logic [LW-1:0] VT_PAL   = LW'(V_TOTAL_PAL);
   localparam logic [LW-1:0] ACT_Y0   = LW'(V_ACT_START);
   localparam logic [LW-1:0] ACT_Y1_N = LW'(V_ACT_START + V_ACT_NTSC);
   localparam logic [LW-1:0] ACT_Y1_P = LW'(V_ACT_START + V_ACT_PAL);

   logic [1:0]    slot;
   logic [PW-1:0] pix;
   logic [LW-1:0] line;
   logic          field;
   logic          cfg_pal;
   logic          cfg_il;

   logic [LW-1:0] v_total;
   logic [LW-1:0] field_len;
   logic          line_last;
   logic          n_vsync;
   logic          n_hsync;
   logic          n_clamp;
   logic          n_csync;
   logic          active;
   logic [PW-1:0] act_x;
   logic [2:0]    bar;
   logic [6:0]    r;
   logic [6:0]    g;
   logic [6:0]    b;
   logic [6:0]    d_next;
   logic          sof_next;

   // Decode sync levels, pattern colour and the slot payload from the current counters
   always_comb begin
      v_total   = cfg_pal ? VT_PAL : VT_NTSC;
      field_len = (cfg_il && field) ? v_total - LW'(1) : v_total;
      line_last = (line == field_len - LW'(1));

      // Odd field: vsync aligned with hsync; even field: starts half a line in
      if (field)
         n_vsync = !(line < VS_LINES);
      else
         n_vsync = !((line == '0 && pix >= PIX_HALF) ||
                     (line != '0 && line < VS_LINES) ||
                     (line == VS_LINES && pix < PIX_HALF));

      n_hsync = (pix >= HS_END);
      n_clamp = !(pix >= CL_START && pix < CL_END) || !n_vsync;
      n_csync = n_hsync & n_vsync;

      active = pat_en_i && pix >= ACT_X0 && pix < ACT_X1 &&
               line >= ACT_Y0 && line < (cfg_pal ? ACT_Y1_P : ACT_Y1_N);
      act_x  = pix - ACT_X0;
      bar    = 3'(act_x / BAR_WP);
      r      = (active && bar[2]) ? 7'h7F : 7'h00;
      g      = (active && bar[1]) ? 7'h7F : 7'h00;
      b      = (active && bar[0]) ? 7'h7F : 7'h00;

      case (slot)
         2'd0:    d_next = {3'b000, n_vsync, n_clamp, n_hsync, n_csync};
         2'd1:    d_next = r;
         2'd2:    d_next = g;
         default: d_next = b;
      endcase

      sof_next = (slot == 2'd0) && (line == '0) && (pix == (field ? PW'(0) : PIX_HALF));
   end

   // Slot/pixel/line/field counters; mode inputs are only taken at field boundaries
   always_ff @(posedge nCLK or posedge RST) begin
      if (RST) begin
         slot    <= 2'd0;
         pix     <= '0;
         line    <= '0;
         field   <= 1'b1;
         cfg_pal <= vmode_i;
         cfg_il  <= n480i_i;
      end else begin
         slot <= slot + 2'd1;
         if (slot == 2'd3) begin
            if (pix == PIX_LAST) begin
               pix <= '0;
               if (line_last) begin
                  line    <= '0;
                  cfg_pal <= vmode_i;
                  cfg_il  <= n480i_i;
                  field   <= n480i_i ? ~field : 1'b1;
               end else begin
                  line <= line + LW'(1);
               end
            end else begin
               pix <= pix + PW'(1);
            end
         end
      end
   end

   // Register every bus output one nCLK behind the counter state
   always_ff @(posedge nCLK or posedge RST) begin
      if (RST) begin
         vbus.nDSYNC <= 1'b1;
         vbus.D      <= 7'h00;
         vbus.field  <= 1'b1;
         vbus.sof    <= 1'b0;
      end else begin
         vbus.nDSYNC <= (slot != 2'd0);
         vbus.D      <= d_next;
         vbus.field  <= field;
         vbus.sof    <= sof_next;
      end
   end

endmodule
